// File: rtl/dbg_access_seq_if.sv
// Command/response and downstream debug-register bundle for dbg_access_seq.
// master: the command issuer and downstream register model; slave: the sequencer.
interface dbg_access_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_write;
    logic [31:0] dbg_rdata;
    logic        busy;

    modport master (
        output cmd_valid, cmd_read, cmd_addr, cmd_wdata, rsp_ready, dbg_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, dbg_addr, dbg_wdata, dbg_write, busy
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_addr, cmd_wdata, rsp_ready, dbg_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, dbg_addr, dbg_wdata, dbg_write, busy
    );
endinterface

// File: rtl/dbg_access_seq.sv
// Debug access sequencer: turns debug commands into held/settled strobes on the
// debug register port and returns exactly one response per command.
module dbg_access_seq #(
    parameter int unsigned HOLD_CYCLES   = 3,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             i_sys_clk,
    input  logic             i_trst_n,
    dbg_access_seq_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StStrobe, StSettle, StRsp} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_read_q, is_read_d;
    logic [7:0]  dbg_addr_q, dbg_addr_d;
    logic [31:0] dbg_wdata_q, dbg_wdata_d;
    logic        dbg_write_q, dbg_write_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] sh00_q, sh00_d, sh08_q, sh08_d, sh0c_q, sh0c_d;

    logic        addr_wr, addr_ro, strobe_cmd, err_cmd;
    logic [31:0] shadow_sel;

    always_comb begin
        addr_wr    = 1'b0;
        addr_ro    = 1'b0;
        shadow_sel = '0;
        case (bus.cmd_addr)
            8'h00:   begin addr_wr = 1'b1; shadow_sel = sh00_q; end
            8'h08:   begin addr_wr = 1'b1; shadow_sel = sh08_q; end
            8'h0C:   begin addr_wr = 1'b1; shadow_sel = sh0c_q; end
            8'h04, 8'h10, 8'h14: addr_ro = 1'b1;
            default: ;
        endcase
        // Writable registers are read from the shadows, never from downstream.
        strobe_cmd = (bus.cmd_read && addr_ro) || (!bus.cmd_read && addr_wr);
        err_cmd    = !(addr_wr || addr_ro) || (!bus.cmd_read && addr_ro);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_read_d   = is_read_q;
        dbg_addr_d  = dbg_addr_q;
        dbg_wdata_d = dbg_wdata_q;
        dbg_write_d = dbg_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        sh00_d      = sh00_q;
        sh08_d      = sh08_q;
        sh0c_d      = sh0c_q;
        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    is_read_d = bus.cmd_read;
                    if (strobe_cmd) begin
                        state_d     = StStrobe;
                        cnt_d       = 8'(HOLD_CYCLES);
                        dbg_addr_d  = bus.cmd_addr;
                        dbg_wdata_d = bus.cmd_read ? 32'h0 : bus.cmd_wdata;
                        dbg_write_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d     = StRsp;
                        cnt_d       = '0;
                        rsp_err_d   = err_cmd;
                        rsp_rdata_d = err_cmd ? 32'h0 : shadow_sel;
                    end
                end
            end
            StStrobe: begin
                if (cnt_q == 8'd1) begin
                    state_d     = StSettle;
                    cnt_d       = 8'(SETTLE_CYCLES);
                    dbg_write_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StSettle: begin
                if (cnt_q == 8'd1) begin
                    state_d = StRsp;
                    cnt_d   = '0;
                    if (is_read_q) begin
                        rsp_rdata_d = bus.dbg_rdata;
                    end else begin
                        case (dbg_addr_q)
                            8'h00:   sh00_d = dbg_wdata_q;
                            8'h08:   sh08_d = dbg_wdata_q;
                            8'h0C:   sh0c_d = dbg_wdata_q;
                            default: ;
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StRsp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_trst_n) begin
        if (!i_trst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            is_read_q   <= 1'b0;
            dbg_addr_q  <= 8'h04;
            dbg_wdata_q <= '0;
            dbg_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            sh00_q      <= '0;
            sh08_q      <= '0;
            sh0c_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_read_q   <= is_read_d;
            dbg_addr_q  <= dbg_addr_d;
            dbg_wdata_q <= dbg_wdata_d;
            dbg_write_q <= dbg_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            sh00_q      <= sh00_d;
            sh08_q      <= sh08_d;
            sh0c_q      <= sh0c_d;
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.rsp_valid = (state_q == StRsp);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.dbg_addr  = dbg_addr_q;
    assign bus.dbg_wdata = dbg_wdata_q;
    assign bus.dbg_write = dbg_write_q;

endmodule

// File: tb/tb_dbg_access_seq.sv
// Scoreboard bench for dbg_access_seq: driver pushes model expectations,
// negedge monitors check responses and downstream strobes.
module tb_dbg_access_seq;
    localparam int unsigned HOLD   = 3;
    localparam int unsigned SETTLE = 4;

    logic clk = 1'b0;
    logic trst_n = 1'b0;
    always #5 clk = ~clk;

    dbg_access_seq_if bus ();

    dbg_access_seq #(.HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE)) dut (
        .i_sys_clk (clk),
        .i_trst_n  (trst_n),
        .bus       (bus)
    );

    logic [31:0] ro_mem [256];
    logic [31:0] sh_mem [256];
    assign bus.dbg_rdata = ro_mem[bus.dbg_addr];

    logic rand_ready = 1'b0;
    logic force_ready = 1'b1;
    logic rdy_rand = 1'b1;
    assign bus.rsp_ready = rand_ready ? rdy_rand : force_ready;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [31:0] rdata; logic err; int due;} rsp_t;
    typedef struct {logic [7:0] addr; logic [31:0] wdata; int start;} stb_t;
    rsp_t rsp_q[$];
    stb_t stb_q[$];
    bit   rsp_seen = 1'b0;
    int   stb_cnt = 0;
    rsp_t mr;
    stb_t ms;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural reference: address map rules applied directly.
    task automatic model(input logic rd, input logic [7:0] a, input logic [31:0] wd,
                         output logic err, output logic [31:0] rdata, output logic strobed);
        bit wr = a inside {8'h00, 8'h08, 8'h0C};
        bit ro = a inside {8'h04, 8'h10, 8'h14};
        err = 1'b0; rdata = '0; strobed = 1'b0;
        if ((!wr && !ro) || (!rd && ro)) err = 1'b1;
        else if (rd && wr) rdata = sh_mem[a];
        else if (rd) begin rdata = ro_mem[a]; strobed = 1'b1; end
        else begin sh_mem[a] = wd; strobed = 1'b1; end
    endtask

    task automatic issue(input logic rd, input logic [7:0] a, input logic [31:0] wd);
        int k;
        bit got = 1'b0;
        logic err, strobed;
        logic [31:0] rdata;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_read = rd; bus.cmd_addr = a; bus.cmd_wdata = wd;
        for (int i = 0; i < 300; i++) begin
            if (bus.cmd_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin
            n_vec++; n_fail++;
            $display("FAIL accept_timeout: addr %h never accepted", a);
            bus.cmd_valid = 1'b0;
            return;
        end
        k = cyc + 1;
        model(rd, a, wd, err, rdata, strobed);
        rsp_q.push_back('{rdata: rdata, err: err, due: strobed ? k + int'(HOLD + SETTLE) : k});
        if (strobed) stb_q.push_back('{addr: a, wdata: rd ? 32'h0 : wd, start: k});
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_read  = 1'($urandom);
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_wdata = $urandom;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        rdy_rand = 1'($urandom_range(0, 1));
    end

    // Response and strobe monitors.
    always @(negedge clk) begin
        if (trst_n) begin
            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
                end else begin
                    mr = rsp_q[0];
                    if (!rsp_seen) begin
                        check("rsp_latency", cyc, mr.due);
                        rsp_seen = 1'b1;
                    end
                    check("rsp_rdata", bus.rsp_rdata, mr.rdata);
                    check("rsp_err", 32'(bus.rsp_err), 32'(mr.err));
                    check("cmd_ready_in_rsp", 32'(bus.cmd_ready), 32'h0);
                    if (bus.rsp_ready) begin
                        void'(rsp_q.pop_front());
                        rsp_seen = 1'b0;
                    end
                end
            end
            if (bus.dbg_write) begin
                if (stb_q.size() == 0) begin
                    check("unexpected_strobe", 32'(bus.dbg_write), 32'h0);
                end else begin
                    ms = stb_q[0];
                    if (stb_cnt == 0) check("strobe_start", cyc, ms.start);
                    check("strobe_addr", 32'(bus.dbg_addr), 32'(ms.addr));
                    check("strobe_wdata", bus.dbg_wdata, ms.wdata);
                    stb_cnt++;
                end
            end else if (stb_cnt > 0) begin
                check("strobe_len", stb_cnt, HOLD);
                void'(stb_q.pop_front());
                stb_cnt = 0;
            end
        end
    end

    initial begin
        logic [7:0] a;
        bit got;
        for (int i = 0; i < 256; i++) begin ro_mem[i] = $urandom; sh_mem[i] = '0; end
        ro_mem[8'h04] = 32'h0000_0015;
        bus.cmd_valid = 1'b0; bus.cmd_read = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_dbg_addr", 32'(bus.dbg_addr), 32'h04);
        check("rst_dbg_write", 32'(bus.dbg_write), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        trst_n = 1'b1;

        issue(1'b0, 8'h00, 32'h0000_000F);
        issue(1'b1, 8'h00, 32'h0);
        issue(1'b1, 8'h04, 32'h0);
        issue(1'b0, 8'h04, 32'h1234_5678);
        issue(1'b1, 8'h18, 32'h0);

        // Stall the response; a second command must wait behind it.
        force_ready = 1'b0;
        fork
            begin
                issue(1'b1, 8'h00, 32'h0);
                issue(1'b0, 8'h0C, 32'hA5A5_0001);
            end
            begin
                got = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (bus.rsp_valid) begin got = 1'b1; break; end
                end
                check("hold_rsp_seen", 32'(got), 32'h1);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("hold_rsp_valid", 32'(bus.rsp_valid), 32'h1);
                end
                force_ready = 1'b1;
            end
        join
        issue(1'b1, 8'h0C, 32'h0);

        // Reset during the second strobe cycle aborts with no response.
        issue(1'b0, 8'h08, 32'hDEAD_BEEF);
        @(posedge clk);
        #2;
        trst_n = 1'b0;
        #1;
        check("abort_dbg_write", 32'(bus.dbg_write), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_dbg_addr", 32'(bus.dbg_addr), 32'h04);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        rsp_q.delete(); stb_q.delete(); stb_cnt = 0; rsp_seen = 1'b0;
        for (int i = 0; i < 256; i++) sh_mem[i] = '0;
        @(negedge clk);
        trst_n = 1'b1;
        issue(1'b1, 8'h08, 32'h0);
        issue(1'b0, 8'h08, 32'h0BAD_F00D);
        issue(1'b1, 8'h08, 32'h0);

        rand_ready = 1'b1;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0: a = 8'h00;
                1: a = 8'h08;
                2: a = 8'h0C;
                3: a = 8'h04;
                4: a = 8'h10;
                5: a = 8'h14;
                6: a = 8'h18;
                default: a = 8'($urandom);
            endcase
            issue(1'($urandom), a, $urandom);
        end

        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && stb_q.size() == 0) begin got = 1'b1; break; end
        end
        check("drain", 32'(got), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/dbg_access_seq.md
Name: dbg_access_seq

Overview:
- Debug access sequencer; sits directly upstream of the I2C debug/test register block.
- Accepts debug commands (read/write, 8-bit address, 32-bit data) over a valid/ready interface.
- Drives the debug register port (o_dbg_addr/o_dbg_wdata/o_dbg_write). The write strobe is held and then settled long enough for the downstream 3-flop synchroniser and edge detect. Read data is sampled after settling.
- Returns exactly one response per command. Shadows writable registers so reads never clobber them.

Parameters:
HOLD_CYCLES, 3, cycles o_dbg_write is held high per strobe (legal 3..255)
SETTLE_CYCLES, 4, cycles after strobe falls before i_dbg_rdata is sampled (legal 4..255)

Ports:
i_sys_clk  in  1  system clock
i_trst_n  in  1  reset, asynchronous, active-low
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command ready; high only in IDLE
i_cmd_read  in  1  1=read, 0=write
i_cmd_addr  in  8  debug register address
i_cmd_wdata  in  32  write data (ignored for reads)
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response accept
o_rsp_rdata  out  32  read data (0 for writes and errors)
o_rsp_err  out  1  command rejected
o_dbg_addr  out  8  downstream register address
o_dbg_wdata  out  32  downstream write data
o_dbg_write  out  1  downstream write strobe
i_dbg_rdata  in  32  downstream read data
o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async on i_trst_n low): state IDLE; o_cmd_ready=1; o_rsp_valid=0; o_rsp_rdata=0; o_rsp_err=0; o_dbg_addr=8'h04; o_dbg_wdata=0; o_dbg_write=0; o_busy=0; shadows=0; counter=0.
- Reset mid-operation aborts the strobe immediately with no response. Downstream must be reset alongside; no integrity guarantee otherwise.
- Address map and decode at accept:
  - Writable: 0x00, 0x08, 0x0C.
  - Read-only: 0x04, 0x10, 0x14.
  - Any other address, or a write to a read-only address: error. No strobe; go to RSP next cycle with err=1, rdata=0.
- Reads of writable addresses: no strobe. Go to RSP next cycle with rdata=shadow, err=0.
- States: IDLE, STROBE, SETTLE, RSP.
- IDLE:
  - On i_cmd_valid & o_cmd_ready (edge k), latch the command.
  - Strobed commands (writes to writable addresses, reads of read-only addresses) load o_dbg_addr and o_dbg_wdata; writes use i_cmd_wdata, reads use 0. Then go to STROBE.
  - Others go to RSP.
- STROBE: o_dbg_write=1 for cycles k+1..k+HOLD_CYCLES; o_dbg_addr/wdata stable throughout. Then go to SETTLE.
- SETTLE: o_dbg_write=0 for SETTLE_CYCLES cycles. On the last SETTLE cycle:
  - reads register o_rsp_rdata <= i_dbg_rdata;
  - writes update the matching shadow <= wdata.
  Then go to RSP.
- RSP: o_rsp_valid=1 with data/err stable until i_rsp_ready. On handshake, o_rsp_valid falls next cycle and state returns to IDLE; the next command is accepted at the earliest one cycle later.
- Latency:
  - Strobed: o_rsp_valid first high at cycle k+1+HOLD_CYCLES+SETTLE_CYCLES.
  - Shadow/error: o_rsp_valid high at cycle k+1.
- o_dbg_addr/o_dbg_wdata retain their last value after the command completes, so downstream read selection persists. o_dbg_write is only high in STROBE.
- Commands are never dropped: o_cmd_ready=0 outside IDLE. i_cmd_valid while busy is held off.
- Counter: 8-bit down-counter, reloaded on each state entry. No wrap; a terminal count of 1 triggers the transition.
- i_rsp_ready held high: back-to-back commands allowed; each response lasts exactly 1 cycle.

Test Plan:
- Reset, then write 0x00 data 0x0000_000F → o_dbg_write high exactly 3 cycles with addr 0x00; rsp_valid at k+8, err=0, rdata=0; downstream o_dbg_mode_en/force_sda/force_scl/inject_error all 1.
- Read 0x00 after the above → no strobe; rsp at k+1, rdata=0x0000_000F, err=0.
- Drive i_current_state=4'h5, i_busy=1, then read 0x04 → one strobe with wdata=0; rsp at k+8, rdata=0x0000_0015.
- Write 0x04 → err=1, rdata=0, no strobe. Read 0x18 → err=1, rsp at k+1.
- Hold i_rsp_ready=0 for 10 cycles during RSP → o_rsp_valid/rdata stable, o_cmd_ready=0, new i_cmd_valid ignored; accepted after the response.
- Assert i_trst_n low during STROBE cycle 2 → o_dbg_write=0 and o_busy=0 immediately, o_dbg_addr=0x04, no response; the next command then completes normally.
